// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet sequencer.
//   - tx_packet command codes, 4-bit PID enum and PID byte constants
//   - SYNC byte, CRC16 constants and a byte-wide CRC16 update helper
//   - sequencer state enum
package usb_tx_pkg;

  localparam int unsigned CMD_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned OCC_W  = 7;

  localparam logic [CMD_W-1:0] TX_CMD_ACK   = 3'b001;
  localparam logic [CMD_W-1:0] TX_CMD_NAK   = 3'b010;
  localparam logic [CMD_W-1:0] TX_CMD_STALL = 3'b011;
  localparam logic [CMD_W-1:0] TX_CMD_DATA0 = 3'b100;
  localparam logic [CMD_W-1:0] TX_CMD_DATA1 = 3'b101;

  typedef enum logic [3:0] {
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011
  } pid_e;

  localparam logic [BYTE_W-1:0] PID_BYTE_ACK   = 8'hD2;
  localparam logic [BYTE_W-1:0] PID_BYTE_NAK   = 8'h5A;
  localparam logic [BYTE_W-1:0] PID_BYTE_STALL = 8'h1E;
  localparam logic [BYTE_W-1:0] PID_BYTE_DATA0 = 8'hC3;
  localparam logic [BYTE_W-1:0] PID_BYTE_DATA1 = 8'h4B;

  localparam logic [BYTE_W-1:0] SYNC_BYTE      = 8'h80;
  localparam logic [CRC_W-1:0]  CRC16_INIT     = 16'hFFFF;
  localparam logic [CRC_W-1:0]  CRC16_POLY_REV = 16'hA001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SYNC_W,
    ST_PID,
    ST_PID_W,
    ST_FETCH,
    ST_DATA,
    ST_DATA_W,
    ST_CRC_LO,
    ST_CRC_LO_W,
    ST_CRC_HI,
    ST_CRC_HI_W,
    ST_EOP,
    ST_EOP_W
  } tx_state_e;

  function automatic logic cmd_valid(input logic [CMD_W-1:0] cmd);
    return cmd inside {TX_CMD_ACK, TX_CMD_NAK, TX_CMD_STALL, TX_CMD_DATA0, TX_CMD_DATA1};
  endfunction

  function automatic pid_e cmd_to_pid(input logic [CMD_W-1:0] cmd);
    case (cmd)
      TX_CMD_NAK:   return PID_NAK;
      TX_CMD_STALL: return PID_STALL;
      TX_CMD_DATA0: return PID_DATA0;
      TX_CMD_DATA1: return PID_DATA1;
      default:      return PID_ACK;
    endcase
  endfunction

  function automatic logic pid_is_data(input pid_e pid);
    return pid inside {PID_DATA0, PID_DATA1};
  endfunction

  function automatic logic [BYTE_W-1:0] pid_to_byte(input pid_e pid);
    case (pid)
      PID_NAK:   return PID_BYTE_NAK;
      PID_STALL: return PID_BYTE_STALL;
      PID_DATA0: return PID_BYTE_DATA0;
      PID_DATA1: return PID_BYTE_DATA1;
      default:   return PID_BYTE_ACK;
    endcase
  endfunction

  // Reflected CRC16 over one byte, LSB first.
  function automatic logic [CRC_W-1:0] crc16_update(input logic [CRC_W-1:0] crc,
                                                    input logic [BYTE_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC16_POLY_REV;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register (poly 0x8005 reflected, init 0xFFFF).
//   clk, n_rst  : clock, async active-low reset (register -> init)
//   clear       : reload init value (wins over enable)
//   enable      : fold data_in into the running CRC
//   data_in     : byte to fold in
//   crc         : running CRC register
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [BYTE_W-1:0] data_in,
  output logic [CRC_W-1:0]  crc
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear)       crc_d = CRC16_INIT;
    else if (enable) crc_d = crc16_update(crc_q, data_in);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= CRC16_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/usb_tx_packet_fsm.sv
// USB device transmit packet sequencer: SYNC, PID, payload, CRC16, EOP.
//   tx_packet/tx_start      : command from protocol controller
//   buffer_occupancy/tx_data: TX buffer level and read data (valid cycle after pop)
//   get_tx_data             : buffer pop strobe
//   tx_byte/load_byte       : byte handed to serializer, byte_done when sent
//   send_eop/eop_done       : end-of-packet request and completion
//   tx_busy                 : packet in progress
//   tx_error                : watchdog abort pulse (only with TX_TIMEOUT_EN)
// Optional feature macro: TX_TIMEOUT_EN (255-cycle wait watchdog).
module usb_tx_packet_fsm
  import usb_tx_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [CMD_W-1:0]  tx_packet,
  input  logic              tx_start,
  input  logic [OCC_W-1:0]  buffer_occupancy,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              get_tx_data,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              load_byte,
  input  logic              byte_done,
  output logic              send_eop,
  input  logic              eop_done,
  output logic              tx_busy,
  output logic              tx_error
);

  localparam int unsigned CNT_W = OCC_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_BYTES);

  tx_state_e         state_q, state_d;
  pid_e              pid_q, pid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              load_byte_q, load_byte_d;
  logic              get_tx_data_q, get_tx_data_d;
  logic              send_eop_q, send_eop_d;
  logic              tx_busy_q, tx_busy_d;
  logic              crc_clear;
  logic              crc_en;
  logic [CRC_W-1:0]  crc_val;

`ifdef TX_TIMEOUT_EN
  logic [7:0]        wdog_q, wdog_d;
  logic              tx_error_q, tx_error_d;
  logic              wait_st;
  logic              wait_done;
`endif

  usb_crc16 u_crc16 (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (crc_clear),
    .enable  (crc_en),
    .data_in (tx_data),
    .crc     (crc_val)
  );

  // Next state plus next-cycle outputs decoded from the state being entered.
  always_comb begin
    state_d   = state_q;
    pid_d     = pid_q;
    count_d   = count_q;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
`ifdef TX_TIMEOUT_EN
    wdog_d     = 8'd0;
    tx_error_d = 1'b0;
    wait_st    = 1'b0;
    wait_done  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_start && cmd_valid(tx_packet)) begin
          pid_d   = cmd_to_pid(tx_packet);
          count_d = '0;
          state_d = ST_SYNC;
          if (pid_is_data(cmd_to_pid(tx_packet))) begin
            count_d   = (buffer_occupancy > MAX_CNT) ? MAX_CNT : buffer_occupancy;
            crc_clear = 1'b1;
          end
        end
      end
      ST_SYNC:   state_d = ST_SYNC_W;
      ST_SYNC_W: if (byte_done) state_d = ST_PID;
      ST_PID:    state_d = ST_PID_W;
      ST_PID_W: begin
        if (byte_done) begin
          if (!pid_is_data(pid_q))   state_d = ST_EOP;
          else if (count_q == '0)    state_d = ST_CRC_LO;
          else                       state_d = ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_DATA;
      ST_DATA: begin
        crc_en  = 1'b1;
        count_d = count_q - CNT_W'(1);
        state_d = ST_DATA_W;
      end
      ST_DATA_W: if (byte_done) state_d = (count_q != '0) ? ST_FETCH : ST_CRC_LO;
      ST_CRC_LO:   state_d = ST_CRC_LO_W;
      ST_CRC_LO_W: if (byte_done) state_d = ST_CRC_HI;
      ST_CRC_HI:   state_d = ST_CRC_HI_W;
      ST_CRC_HI_W: if (byte_done) state_d = ST_EOP;
      ST_EOP:      state_d = ST_EOP_W;
      ST_EOP_W:    if (eop_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

`ifdef TX_TIMEOUT_EN
    // Counter is zero on every non-wait cycle, so it restarts on each *_W entry.
    wait_st   = state_q inside {ST_SYNC_W, ST_PID_W, ST_DATA_W, ST_CRC_LO_W,
                                ST_CRC_HI_W, ST_EOP_W};
    wait_done = (state_q == ST_EOP_W) ? eop_done : byte_done;
    if (wait_st && !wait_done) begin
      if (wdog_q == 8'd254) begin
        state_d    = ST_IDLE;
        tx_error_d = 1'b1;
        crc_clear  = 1'b1;
      end else begin
        wdog_d = wdog_q + 8'd1;
      end
    end
`endif

    load_byte_d   = (state_d inside {ST_SYNC, ST_PID, ST_CRC_LO, ST_CRC_HI}) ||
                    (state_q == ST_DATA);
    get_tx_data_d = (state_d == ST_FETCH);
    send_eop_d    = (state_d == ST_EOP);
    tx_busy_d     = (state_d != ST_IDLE);

    // Buffer data arrives in DATA, so payload bytes load on entry to DATA_W.
    tx_byte_d = tx_byte_q;
    case (state_d)
      ST_SYNC:   tx_byte_d = SYNC_BYTE;
      ST_PID:    tx_byte_d = pid_to_byte(pid_d);
      ST_CRC_LO: tx_byte_d = ~crc_val[7:0];
      ST_CRC_HI: tx_byte_d = ~crc_val[15:8];
      default:   tx_byte_d = tx_byte_q;
    endcase
    if (state_q == ST_DATA) tx_byte_d = tx_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      pid_q         <= PID_ACK;
      count_q       <= '0;
      tx_byte_q     <= '0;
      load_byte_q   <= 1'b0;
      get_tx_data_q <= 1'b0;
      send_eop_q    <= 1'b0;
      tx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      count_q       <= count_d;
      tx_byte_q     <= tx_byte_d;
      load_byte_q   <= load_byte_d;
      get_tx_data_q <= get_tx_data_d;
      send_eop_q    <= send_eop_d;
      tx_busy_q     <= tx_busy_d;
    end
  end

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdog_q     <= 8'd0;
      tx_error_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      tx_error_q <= tx_error_d;
    end
  end

  assign tx_error = tx_error_q;
`else
  assign tx_error = 1'b0;
`endif

  assign tx_byte     = tx_byte_q;
  assign load_byte   = load_byte_q;
  assign get_tx_data = get_tx_data_q;
  assign send_eop    = send_eop_q;
  assign tx_busy     = tx_busy_q;

endmodule

// File: tb/tb_usb_tx_packet_fsm.sv
// Self-checking bench for usb_tx_packet_fsm: serializer/buffer models plus a
// packet-level reference (byte stream built from PID table, payload, CRC16).
module tb_usb_tx_packet_fsm;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic       tx_start;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_data;
  logic       get_tx_data;
  logic [7:0] tx_byte;
  logic       load_byte;
  logic       byte_done;
  logic       send_eop;
  logic       eop_done;
  logic       tx_busy;
  logic       tx_error;

  int n_assert = 0;
  int n_fail   = 0;

  // Serializer / buffer model state
  bq_t rec;
  bq_t bq;
  int  pops = 0, eops = 0, cyc = 0, cd = 0, ecd = 0;
  int  hold_after = 1000;
  int  load_cyc = 0, eop_done_cyc = 0, busy_fall_cyc = 0, err_cyc = 0;
  bit  err_seen = 0, busy_prev = 0;

  usb_tx_packet_fsm dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .tx_packet        (tx_packet),
    .tx_start         (tx_start),
    .buffer_occupancy (buffer_occupancy),
    .tx_data          (tx_data),
    .get_tx_data      (get_tx_data),
    .tx_byte          (tx_byte),
    .load_byte        (load_byte),
    .byte_done        (byte_done),
    .send_eop         (send_eop),
    .eop_done         (eop_done),
    .tx_busy          (tx_busy),
    .tx_error         (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer and TX buffer behaviour, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!n_rst) begin
      byte_done = 1'b0;
      eop_done  = 1'b0;
      cd = 0;
      ecd = 0;
    end else begin
      byte_done = 1'b0;
      eop_done  = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) byte_done = 1'b1;
      end
      if (ecd > 0) begin
        ecd--;
        if (ecd == 0) begin
          eop_done = 1'b1;
          eop_done_cyc = cyc;
        end
      end
      if (load_byte) begin
        rec.push_back(tx_byte);
        load_cyc = cyc;
        if (rec.size() < hold_after) cd = int'($urandom_range(5, 2));
      end
      if (get_tx_data) begin
        pops++;
        tx_data = (bq.size() > 0) ? bq.pop_front() : 8'h00;
      end
      if (send_eop) begin
        eops++;
        ecd = int'($urandom_range(4, 1));
      end
      if (tx_error && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
      if (busy_prev && !tx_busy) busy_fall_cyc = cyc;
    end
    busy_prev = tx_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_pid_byte(input logic [2:0] code);
    case (code)
      3'd1: return 8'hD2;
      3'd2: return 8'h5A;
      3'd3: return 8'h1E;
      3'd4: return 8'hC3;
      default: return 8'h4B;
    endcase
  endfunction

  // Non-reflected shift-left LFSR on poly 0x8005 fed LSB-first, then mirrored.
  function automatic logic [15:0] ref_crc(input bq_t d);
    logic [15:0] c, r;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ d[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int j = 0; j < 16; j++) r[j] = c[15-j];
    return r;
  endfunction

  function automatic bq_t exp_stream(input logic [2:0] code, input bq_t pl, input int occ);
    bq_t s, d;
    logic [15:0] crc;
    int n;
    n = (occ > 64) ? 64 : occ;
    s.push_back(8'h80);
    s.push_back(ref_pid_byte(code));
    if (code >= 3'd4) begin
      for (int i = 0; i < n; i++) d.push_back(pl[i]);
      crc = ref_crc(d);
      foreach (d[i]) s.push_back(d[i]);
      s.push_back(~crc[7:0]);
      s.push_back(~crc[15:8]);
    end
    return s;
  endfunction

  task automatic start_cmd(input logic [2:0] code);
    @(negedge clk); #1;
    tx_packet = code;
    tx_start  = 1'b1;
    @(negedge clk); #1;
    tx_start  = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input logic [2:0] code, input int occ,
                         input bq_t pl, input bit inject);
    bq_t exp;
    int n;
    rec.delete();
    bq   = pl;
    pops = 0;
    eops = 0;
    buffer_occupancy = 7'(occ);
    start_cmd(code);
    if (inject) begin
      repeat (30) @(negedge clk);
      #1;
      tx_packet = 3'b001;
      tx_start  = 1'b1;
      @(negedge clk); #1;
      tx_start  = 1'b0;
    end
    for (int t = 0; t < 5000 && tx_busy; t++) begin
      @(negedge clk); #1;
    end
    check({tag, " idle"}, 32'(tx_busy), 32'd0);
    exp = exp_stream(code, pl, occ);
    n = (code >= 3'd4) ? ((occ > 64) ? 64 : occ) : 0;
    check({tag, " nbytes"}, 32'(rec.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < rec.size(); i++)
      check($sformatf("%s byte%0d", tag, i), 32'(rec[i]), 32'(exp[i]));
    check({tag, " pops"}, 32'(pops), 32'(n));
    check({tag, " eops"}, 32'(eops), 32'd1);
    check({tag, " busy_fall"}, 32'(busy_fall_cyc - eop_done_cyc), 32'd1);
  endtask

  initial begin
    bq_t pl;
    n_rst = 1'b0;
    tx_packet = 3'b000;
    tx_start = 1'b0;
    buffer_occupancy = 7'd0;
    tx_data = 8'h00;
    byte_done = 1'b0;
    eop_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst tx_byte", 32'(tx_byte), 32'h00);
    check("rst load_byte", 32'(load_byte), 32'd0);
    check("rst get_tx_data", 32'(get_tx_data), 32'd0);
    check("rst send_eop", 32'(send_eop), 32'd0);
    check("rst tx_busy", 32'(tx_busy), 32'd0);
    check("rst tx_error", 32'(tx_error), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Handshakes
    pl.delete();
    run_pkt("ack", 3'b001, 0, pl, 0);
    run_pkt("nak", 3'b010, 0, pl, 0);
    run_pkt("stall", 3'b011, 0, pl, 0);

    // Zero-length DATA0
    run_pkt("data0_zlp", 3'b100, 0, pl, 0);
    check("zlp crc lo", 32'(rec.size() > 2 ? rec[2] : 8'hFF), 32'h00);

    // DATA1 "123456789", CRC bytes are the published USB check value
    pl.delete();
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    run_pkt("data1_str", 3'b101, 9, pl, 0);
    check("str crc lo", 32'(rec.size() > 12 ? rec[11] : 8'h00), 32'hC8);
    check("str crc hi", 32'(rec.size() > 12 ? rec[12] : 8'h00), 32'hB4);

    // Random payloads
    for (int k = 0; k < 4; k++) begin
      int n;
      logic [2:0] code;
      n = int'($urandom_range(20, 1));
      code = 3'($urandom_range(5, 4));
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      run_pkt($sformatf("rand%0d", k), code, n, pl, 0);
    end

    // Occupancy above the clamp, with a mid-packet tx_start injected
    pl.delete();
    for (int i = 0; i < 100; i++) pl.push_back(8'($urandom));
    run_pkt("clamp100", 3'b100, 100, pl, 1);

    // Invalid codes are ignored in IDLE
    for (int k = 0; k < 3; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'b110 : ((k == 1) ? 3'b111 : 3'b000);
      rec.delete();
      pops = 0;
      buffer_occupancy = 7'd5;
      start_cmd(bad);
      repeat (20) @(negedge clk);
      #1;
      check($sformatf("bad%0d busy", k), 32'(tx_busy), 32'd0);
      check($sformatf("bad%0d loads", k), 32'(rec.size()), 32'd0);
      check($sformatf("bad%0d pops", k), 32'(pops), 32'd0);
    end

    // Reset during the fifth payload byte
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    rec.delete();
    bq = pl;
    buffer_occupancy = 7'd10;
    start_cmd(3'b100);
    for (int t = 0; t < 500 && rec.size() < 7; t++) begin
      @(negedge clk); #1;
    end
    check("mid rst reached byte5", 32'(rec.size()), 32'd7);
    n_rst = 1'b0;
    #1;
    check("mid rst tx_byte", 32'(tx_byte), 32'h00);
    check("mid rst load_byte", 32'(load_byte), 32'd0);
    check("mid rst get_tx_data", 32'(get_tx_data), 32'd0);
    check("mid rst send_eop", 32'(send_eop), 32'd0);
    check("mid rst tx_busy", 32'(tx_busy), 32'd0);
    check("mid rst tx_error", 32'(tx_error), 32'd0);
    @(negedge clk); #1;
    n_rst = 1'b1;
    pl.delete();
    run_pkt("ack_after_rst", 3'b001, 0, pl, 0);

    // byte_done withheld after the PID
    rec.delete();
    eops = 0;
    err_seen = 1'b0;
    hold_after = 2;
    start_cmd(3'b001);
    for (int t = 0; t < 200 && rec.size() < 2; t++) begin
      @(negedge clk); #1;
    end
    check("hang pid loaded", 32'(rec.size()), 32'd2);
`ifdef TX_TIMEOUT_EN
    for (int t = 0; t < 400 && !err_seen; t++) begin
      @(negedge clk); #1;
    end
    check("wdog seen", 32'(err_seen), 32'd1);
    check("wdog delay", 32'(err_cyc - load_cyc), 32'd256);
    check("wdog busy", 32'(tx_busy), 32'd0);
    @(negedge clk); #1;
    check("wdog pulse", 32'(tx_error), 32'd0);
`else
    repeat (1000) @(negedge clk);
    #1;
    check("hang busy", 32'(tx_busy), 32'd1);
    check("hang tx_error", 32'(tx_error), 32'd0);
    n_rst = 1'b0;
    @(negedge clk); #1;
    n_rst = 1'b1;
`endif
    check("hang loads", 32'(rec.size()), 32'd2);
    check("hang eops", 32'(eops), 32'd0);
    hold_after = 1000;
    pl.delete();
    run_pkt("ack_final", 3'b001, 0, pl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_packet_fsm.md
Name: usb_tx_packet_fsm

Overview:
- Transmit-side packet sequencer for the USB device endpoint. It is the counterpart of the receive control FSM.
- On a command from the protocol controller it emits SYNC, PID, optional payload, CRC16 and EOP, one byte at a time, to the NRZI/bit-stuff serializer.
- Payload is pulled from the TX data buffer. The CRC16 is generated inline as bytes are sent.

Parameters:
- MAX_DATA_BYTES, 64, largest payload per DATA packet; the latched byte count is clamped to this value.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- tx_packet  in  3  command: 001 ACK, 010 NAK, 011 STALL, 100 DATA0, 101 DATA1; other codes invalid
- tx_start  in  1  one-cycle pulse qualifying tx_packet
- buffer_occupancy  in  7  bytes currently held in TX buffer
- tx_data  in  8  buffer read data, valid the cycle after get_tx_data
- get_tx_data  out  1  one-cycle pop strobe to TX buffer
- tx_byte  out  8  byte to serializer; bit0 is transmitted first
- load_byte  out  1  one-cycle strobe; serializer latches tx_byte
- byte_done  in  1  pulse: serializer finished the last loaded byte
- send_eop  out  1  one-cycle strobe; serializer drives SE0,SE0,J
- eop_done  in  1  pulse: EOP complete, line idle
- tx_busy  out  1  high from accepted tx_start until return to IDLE
- tx_error  out  1  one-cycle abort pulse (see Optional Feature)

Behaviour:
- Reset state: IDLE. Reset values: tx_byte=0x00, load_byte=0, get_tx_data=0, send_eop=0, tx_busy=0, tx_error=0. CRC register=0xFFFF, byte counter=0.
- Reset mid-packet: immediate return to IDLE. No EOP is sent; the serializer is reset by the same n_rst.
- States: IDLE, SYNC, SYNC_W, PID, PID_W, FETCH, DATA, DATA_W, CRC_LO, CRC_LO_W, CRC_HI, CRC_HI_W, EOP, EOP_W.
- IDLE:
  - tx_start with a valid code latches the PID.
  - For DATA0/1 it also latches count = min(buffer_occupancy, MAX_DATA_BYTES) and sets CRC=0xFFFF.
  - Then -> SYNC.
  - Invalid code: ignored, stay in IDLE, tx_busy stays 0.
  - tx_start while not IDLE: ignored.
- SYNC: tx_byte=0x80 with load_byte=1 for one cycle (first cycle after tx_start), then -> SYNC_W.
- Every *_W state holds tx_byte stable and waits for byte_done.
  - byte_done is ignored in every other state.
  - load_byte is never reasserted before byte_done.
- PID: tx_byte = {~pid[3:0], pid[3:0]}. Values: ACK 0xD2, NAK 0x5A, STALL 0x1E, DATA0 0xC3, DATA1 0x4B. Load, then -> PID_W.
- After PID_W:
  - Handshake PIDs -> EOP.
  - DATA with count=0 -> CRC_LO.
  - Otherwise -> FETCH.
- FETCH: pulse get_tx_data for one cycle, then -> DATA.
- DATA:
  - Capture tx_data into tx_byte and pulse load_byte.
  - Update the CRC with that byte.
  - Decrement count, then -> DATA_W.
- After DATA_W: count≠0 -> FETCH, else -> CRC_LO.
- CRC16 spec: polynomial x16+x15+x2+1, reflected form 0xA001, LSB-first per byte, init 0xFFFF.
- CRC_LO / CRC_HI: transmit ~CRC[7:0], then ~CRC[15:8].
- EOP: pulse send_eop for one cycle -> EOP_W. eop_done -> IDLE, tx_busy drops the same edge.
- Simultaneous tx_start and eop_done: the command is not accepted, because tx_busy is still high that cycle.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog clears on entry to each *_W state and counts up while waiting.
  - At 255 cycles without byte_done/eop_done: pulse tx_error, force IDLE, reset the CRC.
- Undefined:
  - The block waits indefinitely.
  - tx_error is tied 0 and no watchdog logic is present.

Decomposition:
- Package usb_tx_pkg holds:
  - tx_packet command codes
  - 4-bit PID enum and PID byte constants
  - SYNC_BYTE=0x80
  - CRC16_INIT=0xFFFF, CRC16_POLY_REV=0xA001
  - state enum
- Sub-module usb_crc16:
  - Byte-wide CRC register with clear and enable inputs, plus a data_in[7:0] input.
  - Outputs the running CRC.
  - Shared with the RX CRC checker.

Test Plan:
- ACK: tx_start, tx_packet=001 -> load_byte with 0x80 then 0xD2, one send_eop, no get_tx_data; tx_busy falls on eop_done.
- Zero-length DATA0 (occupancy=0) -> bytes 0x80, 0xC3, 0x00, 0x00, then EOP; zero get_tx_data pulses.
- DATA1 with buffer "123456789" (0x31..0x39) -> 0x80, 0x4B, nine payload bytes, then 0xC8, 0xB4; exactly 9 get_tx_data pulses.
- Occupancy=100 -> exactly 64 pops. Also: tx_start with code 110, and tx_start mid-packet -> both ignored, output stream unchanged.
- n_rst asserted during byte 5 of payload -> all outputs 0 the same cycle. A new ACK after release is sent correctly.
- With TX_TIMEOUT_EN: byte_done withheld after PID -> tx_error pulse 255 cycles into PID_W, then IDLE. Without the macro, the block is still in PID_W after 1000 cycles.
